vga_sync_generator: RTL and testbench

Consumes the one-cycle `pixel_synch_en` strobe from the pixel-enable divider and generates 640x480@60 Hz VGA timing. It produces horizontal/vertical sync, a visible-area flag, the current pixel coordinates and frame/line start pulses. It is the stage between the pixel-enable divider and the pixel colour/renderer logic.

---
 rtl/vga_sync_generator.sv | 92 +++++++++
 tb/tb_vga_sync_generator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: VGA sync, visible-area flag, pixel coordinates and line/frame pulses
// advanced by a one-clk pixel strobe; every output is registered with the counters.
module vga_sync_generator #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_synch_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SP  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BP  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SP  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BP  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {VIS, FRONT, SYNC, BACK} phase_e;

    phase_e     h_st_q, h_st_d, v_st_q, v_st_d;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       hs_q, hs_d, vs_q, vs_d, von_q, von_d, ls_q, ls_d, fs_q, fs_d;
    logic       h_wrap, v_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= H_MAX;
            v_q    <= V_MAX;
            h_st_q <= BACK;
            v_st_q <= BACK;
            hs_q   <= ~SYNC_ACTIVE;
            vs_q   <= ~SYNC_ACTIVE;
            von_q  <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            h_st_q <= h_st_d;
            v_st_q <= v_st_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            von_q  <= von_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
        end
    end

    // Phases are decoded from the next counter values so they land in the same edge as the counters.
    always_comb begin
        h_wrap = pixel_synch_en && (h_q == H_MAX);
        v_wrap = h_wrap && (v_q == V_MAX);
        h_d    = !pixel_synch_en ? h_q : h_wrap ? 10'd0 : h_q + 10'd1;
        v_d    = !h_wrap ? v_q : v_wrap ? 10'd0 : v_q + 10'd1;
        h_st_d = h_d < H_FP ? VIS : h_d < H_SP ? FRONT : h_d < H_BP ? SYNC : BACK;
        v_st_d = v_d < V_FP ? VIS : v_d < V_SP ? FRONT : v_d < V_BP ? SYNC : BACK;
    end

    always_comb begin
        hs_d  = (h_st_d == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_d  = (v_st_d == SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        von_d = (h_st_d == VIS) && (v_st_d == VIS);
        ls_d  = h_wrap;
        fs_d  = v_wrap;
    end

    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = von_q;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: directed vectors on the default timing, an inverted-polarity copy,
// and a shrunken-timing copy so a whole frame fits in a short run.
module tb_vga_sync_generator;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    always #5 clk = ~clk;

    logic       hs, vs, von, ls, fs, hs1, vs1, von1, ls1, fs1, hsm, vsm, vonm, lsm, fsm_o;
    logic [9:0] px, py, px1, py1, pxm, pym;
    logic [24:0] o_main, o_pol;
    assign o_main = {px, py, hs, vs, von, ls, fs};
    assign o_pol  = {px1, py1, hs1, vs1, von1, ls1, fs1};

    vga_sync_generator dut (
        .clk(clk), .rst(rst), .pixel_synch_en(en), .hsync(hs), .vsync(vs), .video_on(von),
        .pixel_x(px), .pixel_y(py), .line_start(ls), .frame_start(fs)
    );
    vga_sync_generator #(.SYNC_ACTIVE(1'b1)) dut_pol (
        .clk(clk), .rst(rst), .pixel_synch_en(en), .hsync(hs1), .vsync(vs1), .video_on(von1),
        .pixel_x(px1), .pixel_y(py1), .line_start(ls1), .frame_start(fs1)
    );
    // 15 x 10 frame: visible 8x4, hsync at x 10..12, vsync at y 5..6
    vga_sync_generator #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                         .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(3)) dut_mini (
        .clk(clk), .rst(rst), .pixel_synch_en(en), .hsync(hsm), .vsync(vsm), .video_on(vonm),
        .pixel_x(pxm), .pixel_y(pym), .line_start(lsm), .frame_start(fsm_o)
    );

    typedef struct {
        logic r, e;
        logic [9:0] x, y;
        logic h, v, vo, l, f;
    } vec_t;

    int vecs = 0, errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_both(input string name, input int x, input int y,
                            input logic h, input logic v, input logic vo, input logic l, input logic f);
        chk(name, 32'(o_main), 32'({10'(x), 10'(y), h, v, vo, l, f}));
        chk({name, "_pol"}, 32'(o_pol), 32'({10'(x), 10'(y), ~h, ~v, vo, l, f}));
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    function automatic vec_t mk(logic r, logic e, int x, int y, logic h, logic v, logic vo, logic l, logic f);
        vec_t t;
        t.r = r; t.e = e; t.x = 10'(x); t.y = 10'(y);
        t.h = h; t.v = v; t.vo = vo; t.l = l; t.f = f;
        return t;
    endfunction

    vec_t tbl[10];
    int gaps[3] = '{1, 3, 7};

    initial begin
        int n, vsa, bad, nv, nls;
        logic [9:0] prev_y;
        logic done;
        tbl[0] = mk(1, 1, 799, 524, 1, 1, 0, 0, 0);
        tbl[1] = mk(1, 0, 799, 524, 1, 1, 0, 0, 0);
        tbl[2] = mk(0, 0, 799, 524, 1, 1, 0, 0, 0);
        tbl[3] = mk(0, 1,   0,   0, 1, 1, 1, 1, 1);
        tbl[4] = mk(0, 0,   0,   0, 1, 1, 1, 0, 0);
        tbl[5] = mk(0, 1,   1,   0, 1, 1, 1, 0, 0);
        tbl[6] = mk(0, 1,   2,   0, 1, 1, 1, 0, 0);
        tbl[7] = mk(0, 0,   2,   0, 1, 1, 1, 0, 0);
        tbl[8] = mk(1, 1, 799, 524, 1, 1, 0, 0, 0);
        tbl[9] = mk(0, 1,   0,   0, 1, 1, 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].e);
            chk_both($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].h, tbl[i].v, tbl[i].vo, tbl[i].l, tbl[i].f);
        end
        // horizontal sweep of line 0
        run(639); chk_both("x639", 639, 0, 1, 1, 1, 0, 0);
        run(1);   chk_both("x640", 640, 0, 1, 1, 0, 0, 0);
        run(15);  chk_both("x655", 655, 0, 1, 1, 0, 0, 0);
        run(1);   chk_both("x656", 656, 0, 0, 1, 0, 0, 0);
        run(95);  chk_both("x751", 751, 0, 0, 1, 0, 0, 0);
        run(1);   chk_both("x752", 752, 0, 1, 1, 0, 0, 0);
        run(47);  chk_both("x799", 799, 0, 1, 1, 0, 0, 0);
        run(1);   chk_both("wrap_y1", 0, 1, 1, 1, 1, 1, 0);
        // strobe held high: clocks between line_start pulses
        n = 0;
        do begin
            step(1'b0, 1'b1);
            n++;
        end while (!ls && n < 2000);
        chk("line_period", 32'(n), 32'd800);
        chk_both("line2", 0, 2, 1, 1, 1, 1, 0);
        // irregular strobe gaps
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b1);
            chk_both($sformatf("gap_strobe%0d", g), g + 1, 2, 1, 1, 1, 0, 0);
            for (int k = 0; k < gaps[g]; k++) begin
                step(1'b0, 1'b0);
                chk_both($sformatf("gap_hold%0d_%0d", g, k), g + 1, 2, 1, 1, 1, 0, 0);
            end
        end
        run(796);          chk_both("gap_x799", 799, 2, 1, 1, 0, 0, 0);
        step(1'b0, 1'b1);  chk_both("gap_wrap", 0, 3, 1, 1, 1, 1, 0);
        step(1'b0, 1'b0);  chk_both("gap_pulse_drop", 0, 3, 1, 1, 1, 0, 0);
        // reset mid-line coincident with a strobe
        run(300);          chk_both("pre_reset", 300, 3, 1, 1, 1, 0, 0);
        step(1'b1, 1'b1);  chk_both("mid_reset", 799, 524, 1, 1, 0, 0, 0);
        step(1'b0, 1'b0);  chk_both("reset_hold", 799, 524, 1, 1, 0, 0, 0);
        step(1'b0, 1'b1);  chk_both("reset_first", 0, 0, 1, 1, 1, 1, 1);
        chk("mini_start", 32'({pxm, pym, lsm, fsm_o}), 32'({10'd0, 10'd0, 1'b1, 1'b1}));
        // full frame on the shrunken timing
        n = 0; vsa = 0; bad = 0; nv = 0; nls = 0; prev_y = pym; done = 1'b0;
        while (!done && n < 1000) begin
            step(1'b0, 1'b1);
            n++;
            if (!vsm) vsa++;
            if (!vsm && !(pym == 10'd5 || pym == 10'd6)) bad++;
            if (vonm && pym >= 10'd4) bad++;
            if (vonm) nv++;
            if (lsm) nls++;
            if (fsm_o) begin
                done = 1'b1;
                chk("mini_wrap_y", 32'({prev_y, pym, pxm}), 32'({10'd9, 10'd0, 10'd0}));
            end
            prev_y = pym;
        end
        chk("mini_frame_strobes", 32'(n), 32'd150);
        chk("mini_vsync_clks", 32'(vsa), 32'd30);
        chk("mini_bad_region", 32'(bad), 32'd0);
        chk("mini_visible_px", 32'(nv), 32'd32);
        chk("mini_line_starts", 32'(nls), 32'd10);
        step(1'b0, 1'b0);
        chk("mini_fs_drop", 32'({lsm, fsm_o, hsm}), 32'({1'b0, 1'b0, 1'b1}));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
